// File: rtl/pcla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one SEG_W-bit segment per stage, registered inter-segment carry.
// Optional signed saturation of the result is enabled by defining PCLA_SAT_EN.
module pcla_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SEGS = WIDTH / SEG_W;
  localparam int NGRP = SEG_W / 4;

  // Segment adder: 4-bit lookahead groups, group carries expanded from the segment carry-in.
  function automatic logic [SEG_W:0] segAdd(
    input logic [SEG_W-1:0] x,
    input logic [SEG_W-1:0] y,
    input logic             ci
  );
    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] p;
    logic [SEG_W:0]   c;
    logic [NGRP-1:0]  gg;
    logic [NGRP-1:0]  gp;
    logic [NGRP:0]    gc;
    logic             term;
    g = x & y;
    p = x ^ y;
    for (int j = 0; j < NGRP; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    gc[0] = ci;
    for (int j = 1; j <= NGRP; j++) begin
      term = ci;
      for (int i = 0; i < j; i++) begin
        term = term & gp[i];
      end
      gc[j] = term;
      for (int i = 0; i < j; i++) begin
        term = gg[i];
        for (int m = i + 1; m < j; m++) begin
          term = term & gp[m];
        end
        gc[j] = gc[j] | term;
      end
    end
    for (int j = 0; j < NGRP; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    c[SEG_W] = gc[NGRP];
    return {c[SEG_W], p ^ c[SEG_W-1:0]};
  endfunction

  logic             w_stall;
  logic             w_advance;
  logic             w_accept;
  logic [WIDTH-1:0] w_bEff;
  logic             w_cEff;

  assign w_stall   = out_valid & ~out_ready;
  assign in_ready  = ~w_stall;
  assign w_advance = ~w_stall;
  assign w_accept  = in_valid & in_ready;
  assign w_bEff    = sub ? ~b : b;
  assign w_cEff    = sub | cin;

  // Each intermediate stage keeps only the operand bits still to be added and the result bits so far.
  for (genvar k = 0; k < SEGS - 1; k++) begin : gStage
    localparam int REM = WIDTH - (k + 1) * SEG_W;

    logic                     r_vld;
    logic                     r_carry;
    logic [(k+1)*SEG_W-1:0]   r_sum;
    logic [REM-1:0]           r_a;
    logic [REM-1:0]           r_b;

    logic [SEG_W-1:0]         w_segA;
    logic [SEG_W-1:0]         w_segB;
    logic                     w_segCin;
    logic                     w_inVld;
    logic [REM-1:0]           w_restA;
    logic [REM-1:0]           w_restB;
    logic [SEG_W:0]           w_seg;
    logic [(k+1)*SEG_W-1:0]   w_nextSum;

    if (k == 0) begin : gFirst
      assign w_segA    = a[SEG_W-1:0];
      assign w_segB    = w_bEff[SEG_W-1:0];
      assign w_segCin  = w_cEff;
      assign w_inVld   = w_accept;
      assign w_restA   = a[WIDTH-1:SEG_W];
      assign w_restB   = w_bEff[WIDTH-1:SEG_W];
      assign w_nextSum = w_seg[SEG_W-1:0];
    end else begin : gNext
      assign w_segA    = gStage[k-1].r_a[SEG_W-1:0];
      assign w_segB    = gStage[k-1].r_b[SEG_W-1:0];
      assign w_segCin  = gStage[k-1].r_carry;
      assign w_inVld   = gStage[k-1].r_vld;
      assign w_restA   = gStage[k-1].r_a[REM+SEG_W-1:SEG_W];
      assign w_restB   = gStage[k-1].r_b[REM+SEG_W-1:SEG_W];
      assign w_nextSum = {w_seg[SEG_W-1:0], gStage[k-1].r_sum};
    end

    assign w_seg = segAdd(w_segA, w_segB, w_segCin);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld   <= 1'b0;
        r_carry <= 1'b0;
        r_sum   <= '0;
        r_a     <= '0;
        r_b     <= '0;
      end else if (w_advance) begin
        r_vld   <= w_inVld;
        r_carry <= w_seg[SEG_W];
        r_sum   <= w_nextSum;
        r_a     <= w_restA;
        r_b     <= w_restB;
      end
    end
  end

  logic [SEG_W-1:0] w_lastA;
  logic [SEG_W-1:0] w_lastB;
  logic             w_lastCin;
  logic             w_lastVld;
  logic [SEG_W:0]   w_lastSeg;
  logic [WIDTH-1:0] w_rawF;
  logic [WIDTH-1:0] w_finalF;
  logic             w_cMsb;
  logic             w_rawCout;
  logic             w_rawOvf;

  if (SEGS == 1) begin : gSingle
    assign w_lastA   = a;
    assign w_lastB   = w_bEff;
    assign w_lastCin = w_cEff;
    assign w_lastVld = w_accept;
    assign w_rawF    = w_lastSeg[SEG_W-1:0];
  end else begin : gTail
    assign w_lastA   = gStage[SEGS-2].r_a;
    assign w_lastB   = gStage[SEGS-2].r_b;
    assign w_lastCin = gStage[SEGS-2].r_carry;
    assign w_lastVld = gStage[SEGS-2].r_vld;
    assign w_rawF    = {w_lastSeg[SEG_W-1:0], gStage[SEGS-2].r_sum};
  end

  assign w_lastSeg = segAdd(w_lastA, w_lastB, w_lastCin);
  assign w_rawCout = w_lastSeg[SEG_W];
  // Carry into the MSB recovered from sum = a ^ b ^ carry at that bit.
  assign w_cMsb    = w_lastSeg[SEG_W-1] ^ w_lastA[SEG_W-1] ^ w_lastB[SEG_W-1];
  assign w_rawOvf  = w_cMsb ^ w_rawCout;

`ifdef PCLA_SAT_EN
  assign w_finalF = w_rawOvf ? (w_rawF[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                                : {1'b1, {(WIDTH-1){1'b0}}})
                             : w_rawF;
`else
  assign w_finalF = w_rawF;
`endif

  // Result flags only change when a valid item lands in the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      f         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (w_advance) begin
      out_valid <= w_lastVld;
      if (w_lastVld) begin
        f    <= w_finalF;
        cout <= w_rawCout;
        ovf  <= w_rawOvf;
        zero <= (w_finalF == '0);
      end
    end
  end

endmodule

// File: tb/tb_pcla_addsub.sv
// Directed bench for pcla_addsub: an 8/4 instance (2 stages) and a default 32/8 instance (4 stages).
// Saturated expectations follow PCLA_SAT_EN when the bench is built with it.
module tb_pcla_addsub;

  logic        clk;
  logic        rst_n;

  logic        inValid8, inReady8, cin8, sub8, outValid8, outReady8, cout8, ovf8, zero8;
  logic [7:0]  a8, b8, f8;

  logic        inValid32, inReady32, cin32, sub32, outValid32, outReady32, cout32, ovf32, zero32;
  logic [31:0] a32, b32, f32;

  int checkCount;
  int passCount;
  int failCount;

  logic [7:0] sA [8];
  logic [7:0] sB [8];
  logic       sCin [8];
  logic [7:0] sF [8];
  int         txIdx;
  int         rxIdx;

`ifdef PCLA_SAT_EN
  localparam logic [7:0]  EXP_77_11 = 8'h7F;
  localparam logic [7:0]  EXP_80_01 = 8'h80;
  localparam logic [31:0] EXP_7F_1  = 32'h7FFF_FFFF;
`else
  localparam logic [7:0]  EXP_77_11 = 8'h88;
  localparam logic [7:0]  EXP_80_01 = 8'h7F;
  localparam logic [31:0] EXP_7F_1  = 32'h8000_0000;
`endif

  pcla_addsub #(.WIDTH(8), .SEG_W(4)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid8), .in_ready(inReady8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(outValid8), .out_ready(outReady8),
    .f(f8), .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  pcla_addsub u32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid32), .in_ready(inReady32),
    .a(a32), .b(b32), .cin(cin32), .sub(sub32),
    .out_valid(outValid32), .out_ready(outReady32),
    .f(f32), .cout(cout32), .ovf(ovf32), .zero(zero32)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one op for a single cycle, then counts edges until the result shows (bounded).
  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb,
                               input logic tcin, input logic tsub, output int lat);
    @(negedge clk);
    a8 = ta; b8 = tb; cin8 = tcin; sub8 = tsub; inValid8 = 1'b1;
    @(negedge clk);
    inValid8 = 1'b0;
    lat = 1;
    while (!outValid8 && lat < 6) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic applyStimulusWide(input logic [31:0] ta, input logic [31:0] tb,
                                   input logic tcin, input logic tsub, output int lat);
    @(negedge clk);
    a32 = ta; b32 = tb; cin32 = tcin; sub32 = tsub; inValid32 = 1'b1;
    @(negedge clk);
    inValid32 = 1'b0;
    lat = 1;
    while (!outValid32 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runOp(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tcin, input logic tsub, input logic [7:0] expF,
                       input logic expCout, input logic expOvf, input logic expZero);
    int lat;
    applyStimulus(ta, tb, tcin, tsub, lat);
    checkOutput({tag, ".lat"},  lat,   2);
    checkOutput({tag, ".f"},    f8,    expF);
    checkOutput({tag, ".cout"}, cout8, expCout);
    checkOutput({tag, ".ovf"},  ovf8,  expOvf);
    checkOutput({tag, ".zero"}, zero8, expZero);
  endtask

  task automatic runOpWide(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                           input logic tcin, input logic tsub, input logic [31:0] expF,
                           input logic expCout, input logic expOvf, input logic expZero);
    int lat;
    applyStimulusWide(ta, tb, tcin, tsub, lat);
    checkOutput({tag, ".lat"},  lat,    4);
    checkOutput({tag, ".f"},    f32,    expF);
    checkOutput({tag, ".cout"}, cout32, expCout);
    checkOutput({tag, ".ovf"},  ovf32,  expOvf);
    checkOutput({tag, ".zero"}, zero32, expZero);
  endtask

  initial begin
    checkCount = 0; passCount = 0; failCount = 0;
    clk = 1'b0; rst_n = 1'b0;
    inValid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; outReady8 = 1'b1;
    inValid32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; outReady32 = 1'b1;

    for (int i = 0; i < 8; i++) begin
      sA[i]   = 8'(i * 7 + 3);
      sB[i]   = 8'(i * 9 + 1);
      sCin[i] = 1'(i % 2);
      sF[i]   = sA[i] + sB[i] + {7'b0, sCin[i]};
    end

    // Reset state
    #2;
    checkOutput("rst.outValid8",  outValid8,  0);
    checkOutput("rst.f8",         f8,         0);
    checkOutput("rst.inReady8",   inReady8,   1);
    checkOutput("rst.outValid32", outValid32, 0);
    #10 rst_n = 1'b1;

    // Single directed ops on the 2-stage instance
    runOp("add11",     8'h11, 8'h11, 1'b0, 1'b0, 8'h22,     1'b0, 1'b0, 1'b0);
    runOp("addFF",     8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFE,     1'b1, 1'b0, 1'b0);
    runOp("addFFc",    8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF,     1'b1, 1'b0, 1'b0);
    runOp("add33CC",   8'h33, 8'hCC, 1'b1, 1'b0, 8'h00,     1'b1, 1'b0, 1'b1);
    runOp("sub10_11",  8'h10, 8'h11, 1'b0, 1'b1, 8'hFF,     1'b0, 1'b0, 1'b0);
    runOp("sub55_55",  8'h55, 8'h55, 1'b0, 1'b1, 8'h00,     1'b1, 1'b0, 1'b1);
    runOp("add77_11",  8'h77, 8'h11, 1'b0, 1'b0, EXP_77_11, 1'b0, 1'b1, 1'b0);
    runOp("sub80_01",  8'h80, 8'h01, 1'b0, 1'b1, EXP_80_01, 1'b1, 1'b1, 1'b0);
    runOp("subCinIgn", 8'h20, 8'h01, 1'b1, 1'b1, 8'h1F,     1'b1, 1'b0, 1'b0);
    runOp("segCross",  8'h0F, 8'h01, 1'b0, 1'b0, 8'h10,     1'b0, 1'b0, 1'b0);

    // Back-to-back stream with out_ready held low for three cycles mid-stream
    txIdx = 0;
    rxIdx = 0;
    for (int t = 0; t < 40 && rxIdx < 8; t++) begin
      @(negedge clk);
      outReady8 = !(t >= 4 && t <= 6);
      if (txIdx < 8) begin
        a8 = sA[txIdx]; b8 = sB[txIdx]; cin8 = sCin[txIdx]; sub8 = 1'b0; inValid8 = 1'b1;
      end else begin
        inValid8 = 1'b0;
      end
      #1;
      if (t >= 4 && t <= 6) begin
        checkOutput("stream.stallInReady", inReady8,  0);
        checkOutput("stream.stallValid",   outValid8, 1);
        checkOutput("stream.stallHoldF",   f8,        sF[rxIdx]);
      end
      if (outValid8 && outReady8) begin
        checkOutput("stream.f",    f8,    sF[rxIdx]);
        checkOutput("stream.cout", cout8, 0);
        rxIdx++;
      end
      if (inValid8 && inReady8) txIdx++;
    end
    inValid8 = 1'b0;
    checkOutput("stream.rxCount", rxIdx, 8);
    checkOutput("stream.txCount", txIdx, 8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stream.noExtra", outValid8, 0);
    end

    // Asynchronous reset while stalled with two ops in flight
    @(negedge clk);
    outReady8 = 1'b0;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0; inValid8 = 1'b1;
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01;
    @(negedge clk);
    inValid8 = 1'b0;
    checkOutput("preRst.outValid", outValid8, 1);
    checkOutput("preRst.f",        f8,        8'h46);
    checkOutput("preRst.inReady",  inReady8,  0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRst.outValid", outValid8, 0);
    checkOutput("midRst.f",        f8,        0);
    checkOutput("midRst.cout",     cout8,     0);
    checkOutput("midRst.inReady",  inReady8,  1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    outReady8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("postRst.idle", outValid8, 0);
    end
    runOp("postRst", 8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);

    // Default 32/8 instance: four stages
    runOpWide("w.wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    runOpWide("w.ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, EXP_7F_1,      1'b0, 1'b1, 1'b0);
    runOpWide("w.subEq",  32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    runOpWide("w.carry",  32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
